uc_envia_quadro: RTL and testbench

UC_ENVIA_QUADRO -- requirements
Module: uc_envia_quadro

---
 rtl/uc_envia_quadro_if.sv | 62 ++++++
 rtl/uc_envia_quadro.sv | 249 ++++++++++++++++++++++++
 tb/tb_uc_envia_quadro.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uc_envia_quadro_if.sv
// ---------------------------------------------------------------------------
// uc_envia_quadro_if
// Bundle of the frame-sender control and data signals.
//   slave  modport : seen by uc_envia_quadro (requests, lengths, memory data,
//                    UART done in; UART start/data, indices, status out)
//   master modport : seen by whatever drives the sender (host logic / bench)
// Signals:
//   enviar_dados                 frame start request
//   seg_len[NUM_SEG*LEN_W]       packed per-segment byte counts
//   byte_in[8]                   byte addressed by seg_idx/byte_idx
//   acabou_transmissao_uart_tx   UART TX done pulse
//   iniciar_transmissao_uart_tx  one-cycle UART start pulse
//   dado_tx[8]                   registered byte for the UART
//   seg_idx[3], byte_idx[LEN_W]  memory address of the current byte
//   ocupado                      frame in progress
//   terminou_de_enviar_dados     one-cycle frame-done pulse
//   db_estado[4]                 debug state code
// ---------------------------------------------------------------------------
interface uc_envia_quadro_if #(
  parameter int NUM_SEG = 6,
  parameter int LEN_W   = 6
);
  logic                     enviar_dados;
  logic [NUM_SEG*LEN_W-1:0] seg_len;
  logic [7:0]               byte_in;
  logic                     acabou_transmissao_uart_tx;
  logic                     iniciar_transmissao_uart_tx;
  logic [7:0]               dado_tx;
  logic [2:0]               seg_idx;
  logic [LEN_W-1:0]         byte_idx;
  logic                     ocupado;
  logic                     terminou_de_enviar_dados;
  logic [3:0]               db_estado;

  modport slave (
    input  enviar_dados,
    input  seg_len,
    input  byte_in,
    input  acabou_transmissao_uart_tx,
    output iniciar_transmissao_uart_tx,
    output dado_tx,
    output seg_idx,
    output byte_idx,
    output ocupado,
    output terminou_de_enviar_dados,
    output db_estado
  );

  modport master (
    output enviar_dados,
    output seg_len,
    output byte_in,
    output acabou_transmissao_uart_tx,
    input  iniciar_transmissao_uart_tx,
    input  dado_tx,
    input  seg_idx,
    input  byte_idx,
    input  ocupado,
    input  terminou_de_enviar_dados,
    input  db_estado
  );
endinterface

// File: rtl/uc_envia_quadro.sv
// ---------------------------------------------------------------------------
// uc_envia_quadro
// Control unit that walks a segmented frame stored in an external memory and
// hands it to a UART transmitter one byte at a time.
//   clock  : single clock, all state on the rising edge
//   reset  : asynchronous, active-high
//   bus    : uc_envia_quadro_if.slave (see interface header for signals)
// Parameters:
//   NUM_SEG (2..8)  number of segments in the frame
//   LEN_W           width of each segment byte count
//   MEM_LAT (0..3)  cycles from an index change until byte_in is valid
// Build option:
//   UC_ENVIA_QUADRO_CHECKSUM_EN  when defined, an XOR checksum byte of all
//   data bytes is sent after the last segment.
// Timing note: the start pulse is decoded from the inicia state, and dado_tx
// is loaded on the edge that leaves inicia, so the UART sees the new byte
// from the cycle after the start pulse onwards. byte_in is sampled during
// inicia, which gives the memory MEM_LAT full cycles after the index moves.
// ---------------------------------------------------------------------------
module uc_envia_quadro #(
  parameter int NUM_SEG = 6,
  parameter int LEN_W   = 6,
  parameter int MEM_LAT = 1
) (
  input logic              clock,
  input logic              reset,
  uc_envia_quadro_if.slave bus
);

  typedef enum logic [3:0] {
    INICIAL         = 4'd0,
    ESPERA          = 4'd1,
    CARREGA         = 4'd2,
    PULA            = 4'd3,
    ESPERA_MEM      = 4'd4,
    INICIA          = 4'd5,
    ESPERA_TX       = 4'd6,
    AVANCA          = 4'd7,
`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
    CHECKSUM        = 4'd8,
    ESPERA_CHECKSUM = 4'd9,
`endif
    SINALIZA        = 4'd10
  } estado_t;

  localparam logic [2:0] LAST_SEG = 3'(NUM_SEG - 1);
  localparam logic [1:0] MEM_LAST = (MEM_LAT == 0) ? 2'd0 : 2'(MEM_LAT - 1);

  estado_t                  estado_reg, estado_next;
  logic [NUM_SEG*LEN_W-1:0] seg_len_reg, seg_len_next;
  logic [2:0]               seg_idx_reg, seg_idx_next;
  logic [LEN_W-1:0]         byte_idx_reg, byte_idx_next;
  logic [7:0]               dado_reg, dado_next;
  logic [1:0]               mem_cnt_reg, mem_cnt_next;
`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
  logic [7:0]               acc_reg, acc_next;
`endif

  // Snapshot unpacked into a fixed 8-entry table so a 3-bit seg_idx always
  // addresses a legal entry; entries beyond NUM_SEG read as empty.
  logic [LEN_W-1:0] len_arr [8];
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_len
      if (gi < NUM_SEG) begin : g_used
        assign len_arr[gi] = seg_len_reg[gi*LEN_W +: LEN_W];
      end else begin : g_unused
        assign len_arr[gi] = '0;
      end
    end
  endgenerate

  logic [LEN_W-1:0] len_cur;
  logic             last_seg;
  logic             last_byte;
  assign len_cur   = len_arr[seg_idx_reg];
  assign last_seg  = (seg_idx_reg == LAST_SEG);
  assign last_byte = (byte_idx_reg == (len_cur - LEN_W'(1)));

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg   <= INICIAL;
      seg_len_reg  <= '0;
      seg_idx_reg  <= '0;
      byte_idx_reg <= '0;
      dado_reg     <= 8'h00;
      mem_cnt_reg  <= 2'd0;
`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
      acc_reg      <= 8'h00;
`endif
    end else begin
      estado_reg   <= estado_next;
      seg_len_reg  <= seg_len_next;
      seg_idx_reg  <= seg_idx_next;
      byte_idx_reg <= byte_idx_next;
      dado_reg     <= dado_next;
      mem_cnt_reg  <= mem_cnt_next;
`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
      acc_reg      <= acc_next;
`endif
    end
  end

  // Next-state and datapath updates
  always_comb begin
    estado_next   = estado_reg;
    seg_len_next  = seg_len_reg;
    seg_idx_next  = seg_idx_reg;
    byte_idx_next = byte_idx_reg;
    dado_next     = dado_reg;
    mem_cnt_next  = mem_cnt_reg;
`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
    acc_next      = acc_reg;
`endif

    case (estado_reg)
      INICIAL: estado_next = ESPERA;

      ESPERA: begin
        if (bus.enviar_dados) estado_next = CARREGA;
      end

      CARREGA: begin
        seg_len_next  = bus.seg_len;
        seg_idx_next  = '0;
        byte_idx_next = '0;
`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
        acc_next      = 8'h00;
`endif
        estado_next   = PULA;
      end

      // Empty segments are skipped one per cycle, staying in pula.
      PULA: begin
        if (len_cur == '0) begin
          if (last_seg) begin
`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
            estado_next = CHECKSUM;
`else
            estado_next = SINALIZA;
`endif
          end else begin
            seg_idx_next = seg_idx_reg + 3'd1;
          end
        end else begin
          mem_cnt_next = 2'd0;
          if (MEM_LAT == 0) estado_next = INICIA;
          else              estado_next = ESPERA_MEM;
        end
      end

      ESPERA_MEM: begin
        if (mem_cnt_reg == MEM_LAST) estado_next  = INICIA;
        else                         mem_cnt_next = mem_cnt_reg + 2'd1;
      end

      INICIA: begin
        dado_next   = bus.byte_in;
`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
        acc_next    = acc_reg ^ bus.byte_in;
`endif
        estado_next = ESPERA_TX;
      end

      ESPERA_TX: begin
        if (bus.acabou_transmissao_uart_tx) estado_next = AVANCA;
      end

      AVANCA: begin
        if (last_byte) begin
          byte_idx_next = '0;
          if (last_seg) begin
`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
            estado_next = CHECKSUM;
`else
            estado_next = SINALIZA;
`endif
          end else begin
            seg_idx_next = seg_idx_reg + 3'd1;
            estado_next  = PULA;
          end
        end else begin
          byte_idx_next = byte_idx_reg + LEN_W'(1);
          mem_cnt_next  = 2'd0;
          if (MEM_LAT == 0) estado_next = INICIA;
          else              estado_next = ESPERA_MEM;
        end
      end

`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
      CHECKSUM: begin
        dado_next   = acc_reg;
        estado_next = ESPERA_CHECKSUM;
      end

      ESPERA_CHECKSUM: begin
        if (bus.acabou_transmissao_uart_tx) estado_next = SINALIZA;
      end
`endif

      SINALIZA: estado_next = ESPERA;

      default: estado_next = INICIAL;
    endcase
  end

  // Outputs decoded from the current state so reset clears them at once.
  logic       iniciar_dec;
  logic       terminou_dec;
  logic       ocupado_dec;
  logic [3:0] db_dec;

  always_comb begin
    iniciar_dec  = 1'b0;
    terminou_dec = 1'b0;
    ocupado_dec  = 1'b1;
    db_dec       = 4'hF;
    case (estado_reg)
      INICIAL, ESPERA: ocupado_dec = 1'b0;
      INICIA:          iniciar_dec = 1'b1;
`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
      CHECKSUM:        iniciar_dec = 1'b1;
`endif
      SINALIZA:        terminou_dec = 1'b1;
      default: ;
    endcase
    case (estado_reg)
      INICIAL, ESPERA, CARREGA, PULA, ESPERA_MEM, INICIA, ESPERA_TX, AVANCA,
`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
      CHECKSUM, ESPERA_CHECKSUM,
`endif
      SINALIZA: db_dec = estado_reg;
      default: begin
        db_dec      = 4'hF;
        ocupado_dec = 1'b0;
      end
    endcase
  end

  assign bus.iniciar_transmissao_uart_tx = iniciar_dec;
  assign bus.terminou_de_enviar_dados    = terminou_dec;
  assign bus.ocupado                     = ocupado_dec;
  assign bus.db_estado                   = db_dec;
  assign bus.dado_tx                     = dado_reg;
  assign bus.seg_idx                     = seg_idx_reg;
  assign bus.byte_idx                    = byte_idx_reg;

endmodule

// File: tb/tb_uc_envia_quadro.sv
// ---------------------------------------------------------------------------
// tb_uc_envia_quadro
// Directed bench for uc_envia_quadro (NUM_SEG=6, LEN_W=6, MEM_LAT=1).
// byte_in is a combinational memory: {0, seg_idx, byte_idx[3:0]} or a table
// indexed by seg_idx. A UART model raises TX done 10 cycles after each start.
// ---------------------------------------------------------------------------
module tb_uc_envia_quadro;
  localparam int NUM_SEG = 6;
  localparam int LEN_W   = 6;
  localparam int MEM_LAT = 1;
`ifdef UC_ENVIA_QUADRO_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  uc_envia_quadro_if #(.NUM_SEG(NUM_SEG), .LEN_W(LEN_W)) bus ();

  uc_envia_quadro #(.NUM_SEG(NUM_SEG), .LEN_W(LEN_W), .MEM_LAT(MEM_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Memory model
  logic [7:0] pattern [8];
  bit         use_table = 1'b0;
  always_comb begin
    if (use_table) bus.byte_in = pattern[bus.seg_idx];
    else           bus.byte_in = {1'b0, bus.seg_idx, bus.byte_idx[3:0]};
  end

  // UART model
  int   tx_timer   = 0;
  logic model_done = 1'b0;
  assign bus.acabou_transmissao_uart_tx = model_done;
  always @(posedge clock) begin
    model_done <= 1'b0;
    if (bus.iniciar_transmissao_uart_tx) tx_timer <= 10;
    else if (tx_timer > 0) begin
      tx_timer <= tx_timer - 1;
      if (tx_timer == 1) model_done <= 1'b1;
    end
  end

  // Monitor: capture dado_tx in the cycle after each start pulse
  logic       start_seen = 1'b0;
  logic [7:0] sent [$];
  int         done_cnt = 0;
  always @(posedge clock) begin
    start_seen <= bus.iniciar_transmissao_uart_tx;
    if (bus.terminou_de_enviar_dados) done_cnt <= done_cnt + 1;
  end
  always @(negedge clock) begin
    if (start_seen) sent.push_back(bus.dado_tx);
  end

  function automatic logic [NUM_SEG*LEN_W-1:0] pack_len(input int l0, l1, l2, l3, l4, l5);
    logic [NUM_SEG*LEN_W-1:0] r;
    r = '0;
    r[0*LEN_W +: LEN_W] = LEN_W'(l0);
    r[1*LEN_W +: LEN_W] = LEN_W'(l1);
    r[2*LEN_W +: LEN_W] = LEN_W'(l2);
    r[3*LEN_W +: LEN_W] = LEN_W'(l3);
    r[4*LEN_W +: LEN_W] = LEN_W'(l4);
    r[5*LEN_W +: LEN_W] = LEN_W'(l5);
    return r;
  endfunction

  // Waits at negedges for the frame-done pulse; cycles counts negedges.
  task automatic wait_done(input int bound, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clock);
      if (bus.terminou_de_enviar_dados) begin
        ok = 1'b1;
        cycles = i;
        break;
      end
    end
  endtask

  // Request pulse sampled by exactly one rising edge; returns at the
  // negedge after that edge.
  task automatic launch();
    @(negedge clock);
    bus.enviar_dados = 1'b1;
    @(negedge clock);
    bus.enviar_dados = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.db_estado !== 4'd0 || bus.ocupado !== 1'b0 || bus.iniciar_transmissao_uart_tx !== 1'b0 ||
        bus.terminou_de_enviar_dados !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got estado=%h ocupado=%b ini=%b fim=%b required 0 0 0 0",
               bus.db_estado, bus.ocupado, bus.iniciar_transmissao_uart_tx, bus.terminou_de_enviar_dados);
    end
    checks++;
    if (bus.dado_tx !== 8'h00 || bus.seg_idx !== 3'd0 || bus.byte_idx !== '0) begin
      errors++;
      $display("FAIL reset_data: got dado=%h seg=%0d byte=%0d required 00 0 0",
               bus.dado_tx, bus.seg_idx, bus.byte_idx);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.db_estado !== 4'd1) begin
      errors++;
      $display("FAIL reset_release: got estado=%h required 1", bus.db_estado);
    end
    $display("reset: estado after release %0d", bus.db_estado);
  endtask

  task automatic test_basic_timing();
    logic [7:0] ck;
    int cyc, d0;
    bit ok;
    bus.seg_len = pack_len(1, 1, 1, 1, 1, 1);
    sent.delete();
    d0 = done_cnt;
    launch();
    checks++;
    if (bus.ocupado !== 1'b1 || bus.iniciar_transmissao_uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL load_state: got ocupado=%b ini=%b required 1 0", bus.ocupado, bus.iniciar_transmissao_uart_tx);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.iniciar_transmissao_uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL start_early: got ini=%b two edges after request, required 0", bus.iniciar_transmissao_uart_tx);
    end
    @(negedge clock);
    checks++;
    if (bus.iniciar_transmissao_uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: got ini=%b three edges after request, required 1", bus.iniciar_transmissao_uart_tx);
    end
    wait_done(2000, cyc, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done: got no done pulse, required one");
    end
    repeat (2) @(negedge clock);
    checks++;
    if (sent.size() !== 6 + CK) begin
      errors++;
      $display("FAIL basic_count: got %0d starts required %0d", sent.size(), 6 + CK);
    end
    ck = 8'h00;
    for (int i = 0; i < 6; i++) begin
      ck = ck ^ 8'(i * 16);
      checks++;
      if (sent.size() <= i || sent[i] !== 8'(i * 16)) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h required %h", i, (sent.size() > i) ? sent[i] : 8'hxx, 8'(i * 16));
      end
    end
    if (CK == 1) begin
      checks++;
      if (sent.size() <= 6 || sent[6] !== ck) begin
        errors++;
        $display("FAIL basic_checksum: got %h required %h", (sent.size() > 6) ? sent[6] : 8'hxx, ck);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || bus.ocupado !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulses: got done=%0d ocupado=%b required 1 0", done_cnt - d0, bus.ocupado);
    end
    $display("basic frame: %0d bytes sent, %0d done pulses", sent.size(), done_cnt - d0);
  endtask

  task automatic test_skip();
    logic [7:0] exp_b [7];
    int cyc;
    bit ok;
    exp_b = '{8'h00, 8'h10, 8'h30, 8'h31, 8'h32, 8'h40, 8'h50};
    bus.seg_len = pack_len(1, 1, 0, 3, 1, 1);
    sent.delete();
    launch();
    wait_done(3000, cyc, ok);
    repeat (2) @(negedge clock);
    checks++;
    if (!ok || sent.size() !== 7 + CK) begin
      errors++;
      $display("FAIL skip_count: got done=%b starts=%0d required 1 %0d", ok, sent.size(), 7 + CK);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (sent.size() <= i || sent[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL skip_byte%0d: got %h required %h", i, (sent.size() > i) ? sent[i] : 8'hxx, exp_b[i]);
      end
    end
    $display("skip frame: %0d bytes sent", sent.size());
  endtask

  task automatic test_zero();
    int cyc;
    bit ok;
    bus.seg_len = '0;
    sent.delete();
    launch();
    wait_done((CK == 1) ? 100 : 8, cyc, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zero_done: got no done pulse within bound, required one");
    end
    repeat (2) @(negedge clock);
    checks++;
    if (sent.size() !== CK) begin
      errors++;
      $display("FAIL zero_count: got %0d starts required %0d", sent.size(), CK);
    end
    if (CK == 1) begin
      checks++;
      if (sent.size() < 1 || sent[0] !== 8'h00) begin
        errors++;
        $display("FAIL zero_checksum: got %h required 00", (sent.size() > 0) ? sent[0] : 8'hxx);
      end
    end
    $display("zero frame: done after %0d cycles, %0d bytes sent", cyc, sent.size());
  endtask

  task automatic test_checksum();
    logic [7:0] ck;
    int cyc;
    bit ok;
    pattern = '{8'hA5, 8'h5A, 8'hFF, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00};
    use_table = 1'b1;
    bus.seg_len = pack_len(1, 1, 1, 1, 1, 1);
    sent.delete();
    launch();
    wait_done(2000, cyc, ok);
    repeat (2) @(negedge clock);
    use_table = 1'b0;
    checks++;
    if (!ok || sent.size() !== 6 + CK) begin
      errors++;
      $display("FAIL table_count: got done=%b starts=%0d required 1 %0d", ok, sent.size(), 6 + CK);
    end
    ck = 8'h00;
    for (int i = 0; i < 6; i++) begin
      ck = ck ^ pattern[i];
      checks++;
      if (sent.size() <= i || sent[i] !== pattern[i]) begin
        errors++;
        $display("FAIL table_byte%0d: got %h required %h", i, (sent.size() > i) ? sent[i] : 8'hxx, pattern[i]);
      end
    end
    // A5^5A^FF^01^00^10 = 11
    if (CK == 1) begin
      checks++;
      if (sent.size() <= 6 || sent[6] !== ck) begin
        errors++;
        $display("FAIL table_checksum: got %h required %h", (sent.size() > 6) ? sent[6] : 8'hxx, ck);
      end
    end
    $display("table frame: %0d bytes sent, xor %h", sent.size(), ck);
  endtask

  task automatic test_reset_mid();
    int n;
    bit reached;
    bus.seg_len = pack_len(1, 1, 1, 1, 1, 1);
    sent.delete();
    launch();
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      #1;
      if (sent.size() >= 3) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached || bus.db_estado !== 4'd6) begin
      errors++;
      $display("FAIL mid_reach: got reached=%b estado=%h required 1 6", reached, bus.db_estado);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.db_estado !== 4'd0 || bus.ocupado !== 1'b0 || bus.dado_tx !== 8'h00 ||
        bus.seg_idx !== 3'd0 || bus.byte_idx !== '0 || bus.iniciar_transmissao_uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got estado=%h ocupado=%b dado=%h seg=%0d byte=%0d ini=%b required 0 0 00 0 0 0",
               bus.db_estado, bus.ocupado, bus.dado_tx, bus.seg_idx, bus.byte_idx, bus.iniciar_transmissao_uart_tx);
    end
    @(negedge clock);
    reset = 1'b0;
    n = sent.size();
    repeat (40) @(negedge clock);
    #1;
    checks++;
    if (bus.db_estado !== 4'd1 || sent.size() !== n) begin
      errors++;
      $display("FAIL mid_release: got estado=%h new starts=%0d required 1 0", bus.db_estado, sent.size() - n);
    end
    $display("mid-frame reset: %0d bytes before reset, %0d after", n, sent.size() - n);
  endtask

  task automatic test_hold();
    int cyc, n1;
    bit ok, got1;
    bus.seg_len = pack_len(1, 1, 1, 1, 1, 1);
    sent.delete();
    @(negedge clock);
    bus.enviar_dados = 1'b1;
    got1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      if (sent.size() >= 1) begin
        got1 = 1'b1;
        break;
      end
    end
    bus.seg_len = pack_len(2, 2, 2, 2, 2, 2);
    wait_done(2000, cyc, ok);
    #1;
    checks++;
    if (!got1 || !ok || sent.size() !== 6 + CK) begin
      errors++;
      $display("FAIL hold_first: got start=%b done=%b starts=%0d required 1 1 %0d", got1, ok, sent.size(), 6 + CK);
    end
    n1 = sent.size();
    wait_done(4000, cyc, ok);
    bus.enviar_dados = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    checks++;
    if (!ok || sent.size() - n1 !== 12 + CK) begin
      errors++;
      $display("FAIL hold_second: got done=%b starts=%0d required 1 %0d", ok, sent.size() - n1, 12 + CK);
    end
    checks++;
    if (sent.size() < n1 + 3 || sent[n1 + 1] !== 8'h01 || sent[n1 + 2] !== 8'h10) begin
      errors++;
      $display("FAIL hold_bytes: got %h %h required 01 10",
               (sent.size() > n1 + 1) ? sent[n1 + 1] : 8'hxx, (sent.size() > n1 + 2) ? sent[n1 + 2] : 8'hxx);
    end
    checks++;
    if (bus.ocupado !== 1'b0 || bus.db_estado !== 4'd1) begin
      errors++;
      $display("FAIL hold_idle: got ocupado=%b estado=%h required 0 1", bus.ocupado, bus.db_estado);
    end
    $display("held request: frame1 %0d bytes, frame2 %0d bytes", n1, sent.size() - n1);
  endtask

  initial begin
    bus.enviar_dados = 1'b0;
    bus.seg_len      = '0;
    test_reset();
    test_basic_timing();
    test_skip();
    test_zero();
    test_checksum();
    test_reset_mid();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
